// File: rtl/lfsr_prbs_check.sv
// lfsr_prbs_check: self-synchronising PRBS checker.
// Each beat is predicted from the last LFSR_WIDTH received bits.
// A SEARCH/LOCKED state machine qualifies the stream, and a saturating
// counter totals the bit errors seen while locked.
module lfsr_prbs_check #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter                        LFSR_CONFIG  = "FIBONACCI",
    parameter bit                    REVERSE      = 1'b0,
    parameter bit                    INVERT       = 1'b1,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    LOCK_COUNT   = 4,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic                   clear_count,
    output logic [DATA_WIDTH-1:0]  error_out,
    output logic                   error_out_valid,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int PRIME_BEATS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PRIME_W     = $clog2(PRIME_BEATS + 1);
    localparam int GOOD_W      = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W       = $clog2(UNLOCK_COUNT + 1);
    localparam int POP_W       = $clog2(DATA_WIDTH + 1);
    localparam int SUM_W       = ((COUNT_WIDTH > POP_W) ? COUNT_WIDTH : POP_W) + 1;

    // Tap j of the polynomial reads h[j-1]; the top term is always a tap
    // and the constant term never is.
    localparam logic [LFSR_WIDTH-1:0]  TAP_MASK  = {1'b1, LFSR_POLY[LFSR_WIDTH-1:1]};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    if (LFSR_CONFIG != "FIBONACCI") begin : g_config_check
        $error("lfsr_prbs_check: only the FIBONACCI LFSR_CONFIG is supported");
    end

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state;
    logic [LFSR_WIDTH-1:0]  hist;
    logic [PRIME_W-1:0]     prime_cnt;
    logic [GOOD_W-1:0]      good_cnt;
    logic [BAD_W-1:0]       bad_cnt;

    logic [DATA_WIDTH-1:0]  data_prep;
    logic [DATA_WIDTH-1:0]  data_ord;
    logic [DATA_WIDTH-1:0]  err_ord;
    logic [DATA_WIDTH-1:0]  err_mask;
    logic [DATA_WIDTH-1:0]  beat_mask;
    logic [LFSR_WIDTH-1:0]  hist_work;
    logic [LFSR_WIDTH-1:0]  hist_next;
    logic                   primed;
    logic                   beat_errored;
    logic [POP_W-1:0]       pop_cnt;
    logic [COUNT_WIDTH-1:0] count_base;
    logic [SUM_W-1:0]       count_sum;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [GOOD_W-1:0]      good_inc;
    logic [BAD_W-1:0]       bad_inc;

    // Undo inversion and put the beat in stream order, first bit at the MSB.
    always_comb begin
        data_prep = data_in ^ {DATA_WIDTH{INVERT}};
        data_ord  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_ord[i] = REVERSE ? data_prep[DATA_WIDTH-1-i] : data_prep[i];
        end
    end

    // Unrolled serial check: predict each bit, then shift the received bit in.
    always_comb begin
        hist_work = hist;
        err_ord   = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            err_ord[i] = data_ord[i] ^ (^(hist_work & TAP_MASK));
            hist_work  = {hist_work[LFSR_WIDTH-2:0], data_ord[i]};
        end
        hist_next = hist_work;
    end

    // Map errors back to data_in positions and mask them off while priming.
    always_comb begin
        err_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            err_mask[i] = REVERSE ? err_ord[DATA_WIDTH-1-i] : err_ord[i];
        end
        primed       = (prime_cnt == PRIME_W'(PRIME_BEATS));
        beat_mask    = primed ? err_mask : '0;
        beat_errored = |beat_mask;
    end

    // Bit-error popcount and the saturating counter update for this beat.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pop_cnt = pop_cnt + POP_W'(beat_mask[i]);
        end
        count_base = clear_count ? '0 : error_count;
        count_sum  = SUM_W'(count_base) + SUM_W'(pop_cnt);
        count_next = (count_sum > SUM_W'(COUNT_MAX)) ? COUNT_MAX
                                                     : count_sum[COUNT_WIDTH-1:0];
        good_inc   = good_cnt + GOOD_W'(1);
        bad_inc    = bad_cnt + BAD_W'(1);
    end

    // History, priming, lock state machine, registered outputs and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= SEARCH;
            hist            <= '0;
            prime_cnt       <= '0;
            good_cnt        <= '0;
            bad_cnt         <= '0;
            error_out       <= '0;
            error_out_valid <= 1'b0;
            locked          <= 1'b0;
            error_count     <= '0;
        end else begin
            error_out_valid <= data_in_valid;
            if (data_in_valid) begin
                hist      <= hist_next;
                error_out <= beat_mask;
                if (!primed) begin
                    prime_cnt <= prime_cnt + PRIME_W'(1);
                end
                case (state)
                    SEARCH: begin
                        if (primed) begin
                            if (beat_errored) begin
                                good_cnt <= '0;
                            end else if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                                good_cnt <= '0;
                                state    <= LOCKED;
                                locked   <= 1'b1;
                            end else begin
                                good_cnt <= good_inc;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!beat_errored) begin
                            bad_cnt <= '0;
                        end else if (bad_inc == BAD_W'(UNLOCK_COUNT)) begin
                            bad_cnt <= '0;
                            state   <= SEARCH;
                            locked  <= 1'b0;
                        end else begin
                            bad_cnt <= bad_inc;
                        end
                    end
                    default: state <= SEARCH;
                endcase
                if (state == LOCKED) begin
                    error_count <= count_next;
                end else if (clear_count) begin
                    error_count <= '0;
                end
            end else if (clear_count) begin
                error_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// tb_lfsr_prbs_check: directed bench for lfsr_prbs_check.
// dut_a: PRBS31 x^31+x^28+1, 8-bit beats, MSB first, inverted stream.
// dut_b: PRBS7 x^7+x^6+1, 1-bit beats, LSB first, 4-bit error counter.
// A serial reference model pushes expected results to a queue per DUT;
// a negedge monitor pops and compares them as outputs appear.
module tb_lfsr_prbs_check;

    typedef struct {
        logic [7:0]  err;
        logic        locked;
        logic [31:0] count;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_clear;
    logic [7:0]  a_err;
    logic        a_err_valid;
    logic        a_locked;
    logic [31:0] a_count;
    logic [0:0]  b_data;
    logic        b_valid;
    logic        b_clear;
    logic [0:0]  b_err;
    logic        b_err_valid;
    logic        b_locked;
    logic [3:0]  b_count;

    int n_vec = 0;
    int n_err = 0;
    int b_outputs = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;

    // reference model state, index 0 = dut_a, 1 = dut_b
    logic [63:0]     m_tap[2];
    int              m_dw[2];
    bit              m_rev[2];
    int              m_prime_target[2];
    longint unsigned m_cmax[2];
    logic [63:0]     m_hist[2];
    int              m_prime[2];
    int              m_good[2];
    int              m_bad[2];
    bit              m_locked[2];
    longint unsigned m_count[2];

    // stream generators, newest generated bit at index 0
    logic [30:0] ga;
    logic [6:0]  gb;

    lfsr_prbs_check dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_in         (a_data),
        .data_in_valid   (a_valid),
        .clear_count     (a_clear),
        .error_out       (a_err),
        .error_out_valid (a_err_valid),
        .locked          (a_locked),
        .error_count     (a_count)
    );

    lfsr_prbs_check #(
        .LFSR_WIDTH  (7),
        .LFSR_POLY   (7'h41),
        .REVERSE     (1'b1),
        .DATA_WIDTH  (1),
        .COUNT_WIDTH (4)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_in         (b_data),
        .data_in_valid   (b_valid),
        .clear_count     (b_clear),
        .error_out       (b_err),
        .error_out_valid (b_err_valid),
        .locked          (b_locked),
        .error_count     (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_hist[id]   = '0;
            m_prime[id]  = 0;
            m_good[id]   = 0;
            m_bad[id]    = 0;
            m_locked[id] = 1'b0;
            m_count[id]  = 0;
        end
    endtask

    // serial, bit-at-a-time prediction of what the checker must report
    task automatic model_step(input int id, input logic vld, input logic [7:0] data, input logic clr);
        logic [7:0]      d;
        logic [7:0]      mask;
        logic            bitv;
        int              pos;
        int              pc;
        bit              primed;
        bit              was_locked;
        longint unsigned sum;
        exp_t            e;
        if (!vld) begin
            if (clr) m_count[id] = 0;
            return;
        end
        d    = ~data;
        mask = '0;
        for (int k = 0; k < m_dw[id]; k++) begin
            pos       = m_rev[id] ? k : m_dw[id] - 1 - k;
            bitv      = d[pos];
            mask[pos] = bitv ^ (^(m_hist[id] & m_tap[id]));
            m_hist[id] = {m_hist[id][62:0], bitv};
        end
        primed = (m_prime[id] == m_prime_target[id]);
        if (!primed) begin
            mask = '0;
            m_prime[id]++;
        end
        pc         = $countones(mask);
        was_locked = m_locked[id];
        if (was_locked) begin
            sum = clr ? 0 : m_count[id];
            sum = sum + longint'(pc);
            m_count[id] = (sum > m_cmax[id]) ? m_cmax[id] : sum;
            if (pc != 0) begin
                m_bad[id]++;
                if (m_bad[id] == 4) begin
                    m_bad[id]    = 0;
                    m_locked[id] = 1'b0;
                end
            end else begin
                m_bad[id] = 0;
            end
        end else begin
            if (clr) m_count[id] = 0;
            if (primed) begin
                if (pc != 0) begin
                    m_good[id] = 0;
                end else begin
                    m_good[id]++;
                    if (m_good[id] == 4) begin
                        m_good[id]   = 0;
                        m_locked[id] = 1'b1;
                    end
                end
            end
        end
        e.err    = mask;
        e.locked = m_locked[id];
        e.count  = m_count[id][31:0];
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    // one clock cycle: drive at negedge, return just after the posedge
    task automatic applyStimulus(input int id, input logic vld, input logic [7:0] data, input logic clr);
        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = 1'b0;
        a_clear = 1'b0;
        a_data  = 8'($urandom);
        b_valid = 1'b0;
        b_clear = 1'b0;
        b_data  = 1'($urandom);
        if (id == 0) begin
            a_valid = vld;
            a_data  = data;
            a_clear = clr;
        end else begin
            b_valid = vld;
            b_data  = data[0];
            b_clear = clr;
        end
        model_step(id, vld, data, clr);
        @(posedge clk);
        #1;
    endtask

    // reset cycles with a beat presented to dut_a that must be dropped
    task automatic applyReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n   = 1'b0;
            a_valid = 1'b1;
            a_data  = 8'($urandom);
            a_clear = 1'b0;
            b_valid = 1'b0;
            b_data  = 1'b0;
            b_clear = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen_a_word(output logic [7:0] w);
        logic nb;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            nb   = ga[30] ^ ga[27];
            ga   = {ga[29:0], nb};
            w[i] = ~nb;
        end
    endtask

    task automatic gen_a_skip(input int n);
        logic nb;
        for (int i = 0; i < n; i++) begin
            nb = ga[30] ^ ga[27];
            ga = {ga[29:0], nb};
        end
    endtask

    task automatic gen_b_bit(output logic b);
        logic nb;
        nb = gb[6] ^ gb[5];
        gb = {gb[5:0], nb};
        b  = ~nb;
    endtask

    // scoreboard monitor: every valid output must match the oldest prediction
    always @(negedge clk) begin
        if (a_err_valid) begin
            n_vec++;
            assert (q_a.size() > 0) else begin
                n_err++;
                $error("[TB] FAIL a_unexpected_output observed=1 expected=0");
            end
            if (q_a.size() > 0) begin
                mon_e = q_a.pop_front();
                checkOutput("a_error_out", 64'(a_err), 64'(mon_e.err));
                checkOutput("a_locked", 64'(a_locked), 64'(mon_e.locked));
                checkOutput("a_error_count", 64'(a_count), 64'(mon_e.count));
            end
        end
        if (b_err_valid) begin
            b_outputs++;
            n_vec++;
            assert (q_b.size() > 0) else begin
                n_err++;
                $error("[TB] FAIL b_unexpected_output observed=1 expected=0");
            end
            if (q_b.size() > 0) begin
                mon_e = q_b.pop_front();
                checkOutput("b_error_out", 64'(b_err), 64'(mon_e.err));
                checkOutput("b_locked", 64'(b_locked), 64'(mon_e.locked));
                checkOutput("b_error_count", 64'(b_count), 64'(mon_e.count));
            end
        end
    end

    initial begin
        logic [7:0] w;
        logic       bb;
        int         first_lock;
        int         beats_b;
        int         cycles;

        m_tap[0] = 64'h0;
        m_tap[0][30] = 1'b1;
        m_tap[0][27] = 1'b1;
        m_dw[0] = 8;
        m_rev[0] = 1'b0;
        m_prime_target[0] = 4;
        m_cmax[0] = 64'hFFFF_FFFF;
        m_tap[1] = 64'h0;
        m_tap[1][6] = 1'b1;
        m_tap[1][5] = 1'b1;
        m_dw[1] = 1;
        m_rev[1] = 1'b1;
        m_prime_target[1] = 7;
        m_cmax[1] = 64'd15;
        model_reset();

        ga      = 31'h1;
        gb      = 7'h1;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_data  = '0;
        a_clear = 1'b0;
        b_valid = 1'b0;
        b_data  = '0;
        b_clear = 1'b0;

        $display("[TB] reset with a beat presented");
        applyReset(3);
        checkOutput("reset_a_error_out", 64'(a_err), 64'h0);
        checkOutput("reset_a_valid", 64'(a_err_valid), 64'h0);
        checkOutput("reset_a_locked", 64'(a_locked), 64'h0);
        checkOutput("reset_a_count", 64'(a_count), 64'h0);
        checkOutput("reset_b_locked", 64'(b_locked), 64'h0);
        checkOutput("reset_b_count", 64'(b_count), 64'h0);

        $display("[TB] clean PRBS31 stream, 1000 beats");
        first_lock = 0;
        for (int i = 1; i <= 1000; i++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w, 1'b0);
            if (a_locked && first_lock == 0) first_lock = i;
        end
        checkOutput("a_first_lock_beat", 64'(first_lock), 64'd8);
        checkOutput("a_clean_locked", 64'(a_locked), 64'h1);
        checkOutput("a_clean_count", 64'(a_count), 64'h0);

        $display("[TB] single bit error on bit 3");
        gen_a_word(w);
        applyStimulus(0, 1'b1, w ^ 8'h08, 1'b0);
        checkOutput("a_flip_mask", 64'(a_err), 64'h08);
        for (int i = 0; i < 10; i++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w, 1'b0);
        end
        checkOutput("a_flip_count", 64'(a_count), 64'd3);
        checkOutput("a_flip_locked", 64'(a_locked), 64'h1);

        $display("[TB] four all-ones errored beats");
        for (int k = 0; k < 4; k++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w ^ 8'hFF, 1'b0);
            if (k == 2) checkOutput("a_burst_still_locked", 64'(a_locked), 64'h1);
        end
        checkOutput("a_burst_unlocked", 64'(a_locked), 64'h0);
        checkOutput("a_burst_count", 64'(a_count), 64'd32);
        for (int i = 0; i < 20; i++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w, 1'b0);
        end
        checkOutput("a_burst_relocked", 64'(a_locked), 64'h1);
        checkOutput("a_burst_count_frozen", 64'(a_count), 64'd32);

        $display("[TB] stream slip of 5 bits");
        gen_a_skip(5);
        for (int i = 0; i < 40; i++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w, 1'b0);
        end
        checkOutput("a_slip_relocked", 64'(a_locked), 64'h1);

        $display("[TB] clear with a two-bit errored beat");
        gen_a_word(w);
        applyStimulus(0, 1'b1, w ^ 8'h21, 1'b1);
        checkOutput("a_clear_with_beat", 64'(a_count), 64'd2);
        applyStimulus(0, 1'b0, 8'($urandom), 1'b1);
        checkOutput("a_clear_alone", 64'(a_count), 64'd0);
        checkOutput("a_idle_no_valid", 64'(a_err_valid), 64'h0);
        for (int i = 0; i < 10; i++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w, 1'b0);
        end

        $display("[TB] reset while locked");
        applyReset(2);
        checkOutput("a_midreset_locked", 64'(a_locked), 64'h0);
        checkOutput("a_midreset_count", 64'(a_count), 64'h0);
        for (int i = 0; i < 8; i++) begin
            gen_a_word(w);
            applyStimulus(0, 1'b1, w, 1'b0);
        end
        checkOutput("a_midreset_relock", 64'(a_locked), 64'h1);

        $display("[TB] PRBS7 LSB-first with random gaps");
        beats_b = 0;
        cycles  = 0;
        while (beats_b < 60 && cycles < 1000) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_b_bit(bb);
                applyStimulus(1, 1'b1, {7'b0, bb}, 1'b0);
                beats_b++;
            end else begin
                applyStimulus(1, 1'b0, 8'($urandom), 1'b0);
            end
            cycles++;
        end
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        checkOutput("b_gap_locked", 64'(b_locked), 64'h1);
        checkOutput("b_gap_count", 64'(b_count), 64'h0);
        checkOutput("b_outputs_per_beat", 64'(b_outputs), 64'(beats_b));

        $display("[TB] PRBS7 counter saturation");
        for (int f = 0; f < 6; f++) begin
            gen_b_bit(bb);
            applyStimulus(1, 1'b1, {7'b0, ~bb}, 1'b0);
            for (int i = 0; i < 9; i++) begin
                gen_b_bit(bb);
                applyStimulus(1, 1'b1, {7'b0, bb}, 1'b0);
            end
        end
        checkOutput("b_saturated_count", 64'(b_count), 64'd15);
        checkOutput("b_saturated_locked", 64'(b_locked), 64'h1);

        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        checkOutput("a_queue_drained", 64'(q_a.size()), 64'h0);
        checkOutput("b_queue_drained", 64'(q_b.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
